// File: rtl/arb_pkg.sv
// Shared types and constants for the 16-requester round-robin arbiter.
package arb_pkg;

    localparam int N_REQ = 16;
    localparam int IDX_W = 4;

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    typedef logic [IDX_W-1:0] idx_t;

    function automatic logic [N_REQ-1:0] onehot_of(input idx_t i);
        return N_REQ'(1) << i;
    endfunction

endpackage

// File: rtl/rr_pick16.sv
// Combinational round-robin pick: first set request at or after start, wrapping 15->0.
module rr_pick16
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  idx_t             start,
    output logic             found,
    output idx_t             idx
);

    logic [N_REQ-1:0] rotated;
    idx_t             offset;

    // Rotating right by start puts the highest-priority requester at bit 0.
    assign rotated = N_REQ'({req, req} >> start);
    assign found   = |rotated;

    always_comb begin
        // NOTE: assign a default before the loop so no path leaves offset unassigned (no latch).
        offset = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) offset = idx_t'(i);
        end
    end

    assign idx = offset + start;

endmodule

// File: rtl/rr_arbiter_16.sv
// Round-robin owner of the 16:1 mux select; define ARB_TIMEOUT_EN for the hold-limit watchdog.
// The "release" pulse is named release_pulse because release is a reserved word.
module rr_arbiter_16
    import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
    parameter int HOLD_LIMIT = 32
)
`endif
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    input  logic             release_pulse,
    output logic             grant_valid,
    output idx_t             grant_idx,
    output logic [N_REQ-1:0] grant_onehot,
    output logic             timeout
);

    state_t state;
    idx_t   ptr;
    idx_t   pick_start;
    idx_t   pick_idx;
    logic   pick_found;
    logic   owner_req;
    logic   expire;
    logic   end_own;

    assign owner_req = req[grant_idx];

    // While owned, the search starts just past the owner so it is considered last.
    assign pick_start = (state == OWNED) ? grant_idx + idx_t'(1) : ptr;
    assign end_own    = (state == OWNED) && (release_pulse || !owner_req || expire);

    rr_pick16 u_pick (
        .req   (req),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(HOLD_LIMIT + 1);

    logic [CNT_W-1:0] hold_cnt;

    assign expire = (state == OWNED) && (hold_cnt == CNT_W'(HOLD_LIMIT - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            // A voluntary end in the same cycle is not reported as a timeout.
            timeout <= expire && !release_pulse && owner_req;
            if (state == IDLE || end_own) hold_cnt <= '0;
            else                          hold_cnt <= hold_cnt + CNT_W'(1);
        end
    end
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            ptr          <= '0;
            grant_valid  <= 1'b0;
            grant_idx    <= '0;
            grant_onehot <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state        <= OWNED;
                        grant_valid  <= 1'b1;
                        grant_idx    <= pick_idx;
                        grant_onehot <= onehot_of(pick_idx);
                    end
                end
                OWNED: begin
                    if (end_own) begin
                        ptr <= grant_idx + idx_t'(1);
                        if (pick_found) begin
                            grant_idx    <= pick_idx;
                            grant_onehot <= onehot_of(pick_idx);
                        end else begin
                            // grant_idx keeps its value so the mux select stays put.
                            state        <= IDLE;
                            grant_valid  <= 1'b0;
                            grant_onehot <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/rr_arbiter_16.md
Name: rr_arbiter_16

Overview:
Round-robin arbiter that shares one 16:1 selection datapath among 16 requesters. It owns the 4-bit select of the 16-input mux tree and keeps that select stable for the whole ownership period. Requesters raise req and hold it for as long as they need the path. The arbiter grants one requester at a time, with rotating priority so that no requester is starved.

Parameters:
N_REQ, 16, number of requesters; fixed to match the 16:1 mux width.
IDX_W, 4, width of the select/index; equals log2(N_REQ).
HOLD_LIMIT, 32, maximum grant duration in cycles; used only when ARB_TIMEOUT_EN is defined.

Ports:
clock  input  1  single system clock; all state updates on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
req  input  16  per-requester request level; bit i set means requester i wants the path.
release  input  1  single-cycle pulse from the current owner ending its grant.
grant_valid  output  1  high while some requester owns the path.
grant_idx  output  4  index of the owner; drives the mux select.
grant_onehot  output  16  one-hot copy of the grant; all zeros when grant_valid=0.
timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Behaviour:
- Reset (reset_n low, asynchronous): takes effect immediately, including mid-grant.
  - Outputs: grant_valid=0, grant_idx=0, grant_onehot=0, timeout=0.
  - Internal state: state=IDLE, priority pointer ptr=0, hold counter=0.
- FSM states: IDLE and OWNED. All outputs are registered; nothing combinational reaches the outputs.
- Pick function: scan req starting at ptr, ascending, wrapping 15->0; the first set bit wins.
- IDLE:
  - If req!=0: register the winner into grant_idx/grant_onehot, set grant_valid=1, go to OWNED.
  - Latency: req rises at edge k, grant is visible after edge k+1.
  - If req==0: stay in IDLE; grant_idx keeps its last value so the mux select never glitches.
- OWNED, end of ownership:
  - Ownership ends when release=1, or when req[grant_idx]=0 (owner withdrew).
  - On that cycle ptr <= grant_idx+1 mod 16 (15 wraps to 0).
  - A new pick runs in the same cycle using the updated start (grant_idx+1); the current owner is therefore considered last.
  - If the pick finds a winner: back-to-back grant, meaning grant_valid stays 1 and grant_idx changes at the next edge. This includes re-granting the same owner when it is the only requester still asserting req.
  - If no requester remains: grant_valid=0 and grant_onehot=0 at the next edge; go to IDLE.
- OWNED, otherwise: all outputs hold.
- Simultaneous release and req drop by the owner: treated as a single end of ownership.
- release while in IDLE: ignored.
- req changes on non-owners while OWNED: no effect until the next pick.
- grant_onehot always equals (1 << grant_idx) when grant_valid=1.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - A hold counter clears on each new grant and increments every OWNED cycle.
  - When it reaches HOLD_LIMIT-1 with no release, ownership ends exactly as for release. The same rotation and back-to-back pick rules apply.
  - timeout pulses 1 for that one cycle.
- Not defined: no counter is built, timeout is tied to 0, and ownership ends only via release or req drop.

Decomposition:
- Shared package arb_pkg holds:
  - constants N_REQ=16 and IDX_W=4;
  - the state enum {IDLE, OWNED};
  - a typedef for the 4-bit index.
- One sub-module, rr_pick16: purely combinational. It takes req[15:0] and start[3:0] and returns found and idx[3:0]. It is implemented as rotate right by start, find-first-set, then add start mod 16. The top level holds only the FSM, ptr, output registers and the optional counter.

Test Plan:
1. Reset, then req=0x0001 -> after 1 edge grant_valid=1, grant_idx=0, grant_onehot=0x0001; release pulse -> next edge grant_valid=0, ptr=1.
2. req=0xFFFF held, release pulsed every 3 cycles -> grant_idx visits 0,1,2,...,15,0 with no cycle where grant_valid=0.
3. Owner idx=15, req=0x8001, release -> ptr wraps to 0, next grant_idx=0; then release -> grant_idx=15.
4. Single requester req=0x0020, release pulsed while req stays high -> grant_idx stays 5 and grant_valid stays 1 (back-to-back re-grant).
5. reset_n driven low mid-grant, asynchronously between edges -> outputs clear immediately; after reset release, req=0x0300 -> grant_idx=8.
6. With ARB_TIMEOUT_EN and HOLD_LIMIT=4, req=0x0006 with no release -> timeout pulses on the 4th owned cycle, then grant moves 1->2.
